// File: rtl/rx9_align_ctrl.sv
// rx9_align_ctrl: LVDS receiver bring-up sequencer (PLL reset, lock wait) and per-channel bit-slip word aligner.
// Latency: start to done = PLLRST_CYC + LOCK_WAIT + 1 + per-channel check/slip time (17 cycles per clean channel).
// No backpressure; all outputs registered; cda/cda_reset are single-cycle pulses, lock loss restarts from lock wait.
module rx9_align_ctrl #(
  parameter int          NCH        = 9,
  parameter int          W          = 10,
  parameter logic [W-1:0] TRAIN     = 10'h3E0,
  parameter int          PLLRST_CYC = 16,
  parameter int          LOCK_WAIT  = 64,
  parameter int          MATCH_CNT  = 16,
  parameter int          SLIP_GAP   = 8
) (
  input  logic             I_clk,
  input  logic             I_rst,
  input  logic             I_start,
  input  logic             I_rx_locked,
  input  logic [NCH*W-1:0] I_rx_data,
  output logic             O_pll_areset,
  output logic [NCH-1:0]   O_rx_cda_reset,
  output logic [NCH-1:0]   O_rx_cda,
  output logic             O_busy,
  output logic             O_done,
  output logic             O_aligned,
  output logic [NCH-1:0]   O_fail_mask
);

  localparam int CNT_A   = (PLLRST_CYC > LOCK_WAIT) ? PLLRST_CYC : LOCK_WAIT;
  localparam int CNT_MAX = (CNT_A > SLIP_GAP) ? CNT_A : SLIP_GAP;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam int CH_W    = (NCH > 1) ? $clog2(NCH) : 1;
  localparam int SL_W    = (W > 1) ? $clog2(W) : 1;
  localparam int MC_W    = $clog2(MATCH_CNT + 1);

  localparam logic [CNT_W-1:0] CNT_PLLRST = CNT_W'(PLLRST_CYC);
  localparam logic [CNT_W-1:0] CNT_LOCK   = CNT_W'(LOCK_WAIT);
  localparam logic [CNT_W-1:0] CNT_GAP    = CNT_W'(SLIP_GAP);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
  localparam logic [CH_W-1:0]  CH_LAST    = CH_W'(NCH - 1);
  localparam logic [SL_W-1:0]  SLIP_LAST  = SL_W'(W - 1);
  localparam logic [MC_W-1:0]  MC_LAST    = MC_W'(MATCH_CNT - 1);

  typedef enum logic [3:0] {
    ST_IDLE, ST_PLLRST, ST_WLOCK, ST_CDARST, ST_CHECK,
    ST_SLIP, ST_GAP, ST_NEXT, ST_DONE
  } state_t;

  state_t           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [CH_W-1:0]  ch_q;
  logic [SL_W-1:0]  slips_q;
  logic [MC_W-1:0]  mcnt_q;
  logic             pll_areset_q;
  logic [NCH-1:0]   cda_reset_q;
  logic [NCH-1:0]   cda_q;
  logic             busy_q;
  logic             done_q;
  logic             aligned_q;
  logic [NCH-1:0]   fail_q;

  logic [W-1:0]     ch_word;
  logic             word_match;
  logic             lock_lost;

  // Pick the word of the channel currently being aligned.
  always_comb begin
    ch_word = '0;
    for (int c = 0; c < NCH; c++) begin
      if (ch_q == CH_W'(c)) ch_word = I_rx_data[c*W +: W];
    end
  end

  assign word_match = (ch_word == TRAIN);

  // Lock loss only matters once the PLL has been seen locked; a start in DONE takes priority.
  assign lock_lost = !I_rx_locked &&
                     (state_q inside {ST_CDARST, ST_CHECK, ST_SLIP, ST_GAP, ST_NEXT, ST_DONE}) &&
                     !(state_q == ST_DONE && I_start);

  // Bring-up FSM; pulse outputs default low each cycle and are raised only on entry to their state.
  always_ff @(posedge I_clk) begin
    if (I_rst) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      ch_q         <= '0;
      slips_q      <= '0;
      mcnt_q       <= '0;
      pll_areset_q <= 1'b0;
      cda_reset_q  <= '0;
      cda_q        <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      aligned_q    <= 1'b0;
      fail_q       <= '0;
    end else begin
      pll_areset_q <= 1'b0;
      cda_reset_q  <= '0;
      cda_q        <= '0;
      if (lock_lost) begin
        // Any pending slip is dropped: cda_q stays at its default of 0.
        state_q   <= ST_WLOCK;
        cnt_q     <= CNT_LOCK;
        fail_q    <= '0;
        done_q    <= 1'b0;
        aligned_q <= 1'b0;
        busy_q    <= 1'b1;
      end else begin
        case (state_q)
          ST_IDLE: begin
            if (I_start) begin
              state_q      <= ST_PLLRST;
              cnt_q        <= CNT_PLLRST;
              pll_areset_q <= 1'b1;
              busy_q       <= 1'b1;
            end
          end
          ST_PLLRST: begin
            if (cnt_q == CNT_ONE) begin
              state_q <= ST_WLOCK;
              cnt_q   <= CNT_LOCK;
            end else begin
              cnt_q        <= cnt_q - CNT_ONE;
              pll_areset_q <= 1'b1;
            end
          end
          ST_WLOCK: begin
            if (!I_rx_locked) begin
              cnt_q <= CNT_LOCK;
            end else if (cnt_q == CNT_ONE) begin
              state_q     <= ST_CDARST;
              cda_reset_q <= '1;
            end else begin
              cnt_q <= cnt_q - CNT_ONE;
            end
          end
          ST_CDARST: begin
            state_q <= ST_CHECK;
            ch_q    <= '0;
            slips_q <= '0;
            mcnt_q  <= '0;
          end
          ST_CHECK: begin
            if (word_match) begin
              mcnt_q <= mcnt_q + MC_W'(1);
              if (mcnt_q == MC_LAST) state_q <= ST_NEXT;
            end else begin
              mcnt_q <= '0;
              if (slips_q == SLIP_LAST) begin
                fail_q[ch_q] <= 1'b1;
                state_q      <= ST_NEXT;
              end else begin
                slips_q <= slips_q + SL_W'(1);
                cda_q   <= NCH'(1) << ch_q;
                state_q <= ST_SLIP;
              end
            end
          end
          ST_SLIP: begin
            cnt_q   <= CNT_GAP;
            state_q <= ST_GAP;
          end
          ST_GAP: begin
            if (cnt_q == CNT_ONE) begin
              mcnt_q  <= '0;
              state_q <= ST_CHECK;
            end else begin
              cnt_q <= cnt_q - CNT_ONE;
            end
          end
          ST_NEXT: begin
            if (ch_q == CH_LAST) begin
              state_q   <= ST_DONE;
              busy_q    <= 1'b0;
              done_q    <= 1'b1;
              aligned_q <= (fail_q == '0);
            end else begin
              ch_q    <= ch_q + CH_W'(1);
              slips_q <= '0;
              mcnt_q  <= '0;
              state_q <= ST_CHECK;
            end
          end
          ST_DONE: begin
            if (I_start) begin
              state_q      <= ST_PLLRST;
              cnt_q        <= CNT_PLLRST;
              pll_areset_q <= 1'b1;
              busy_q       <= 1'b1;
              fail_q       <= '0;
              done_q       <= 1'b0;
              aligned_q    <= 1'b0;
            end
          end
          default: begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign O_pll_areset   = pll_areset_q;
  assign O_rx_cda_reset = cda_reset_q;
  assign O_rx_cda       = cda_q;
  assign O_busy         = busy_q;
  assign O_done         = done_q;
  assign O_aligned      = aligned_q;
  assign O_fail_mask    = fail_q;

endmodule

// File: tb/tb_rx9_align_ctrl.sv
// Bench for rx9_align_ctrl: table of full bring-up scenarios plus hand-written lock-loss, glitch and reset sequences.
// A channel model rotates each word by one bit per slip pulse; a monitor counts pulses and protocol violations.
module tb_rx9_align_ctrl;
  localparam int NCH = 9;
  localparam int W   = 10;
  localparam logic [W-1:0] TRAIN = 10'h3E0;

  logic             clk = 1'b0;
  logic             I_rst = 1'b1;
  logic             I_start = 1'b0;
  logic             I_rx_locked = 1'b0;
  logic [NCH*W-1:0] I_rx_data;
  logic             O_pll_areset;
  logic [NCH-1:0]   O_rx_cda_reset;
  logic [NCH-1:0]   O_rx_cda;
  logic             O_busy;
  logic             O_done;
  logic             O_aligned;
  logic [NCH-1:0]   O_fail_mask;

  always #5 clk = ~clk;

  rx9_align_ctrl dut (
    .I_clk          (clk),
    .I_rst          (I_rst),
    .I_start        (I_start),
    .I_rx_locked    (I_rx_locked),
    .I_rx_data      (I_rx_data),
    .O_pll_areset   (O_pll_areset),
    .O_rx_cda_reset (O_rx_cda_reset),
    .O_rx_cda       (O_rx_cda),
    .O_busy         (O_busy),
    .O_done         (O_done),
    .O_aligned      (O_aligned),
    .O_fail_mask    (O_fail_mask)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // channel model state
  int             rot_init [NCH];
  int             rot      [NCH];
  int             load_tok = 0;
  int             load_ack = 0;
  logic [NCH-1:0] never_m  = '0;
  logic [NCH-1:0] norot_m  = '0;
  logic           glitch   = 1'b0;

  // monitor counters (only the monitor writes these)
  int             pll_cyc    = 0;
  int             cdarst_cnt = 0;
  int             viol       = 0;
  int             cda_cnt [NCH];
  logic [NCH-1:0] prev_cda   = '0;

  // snapshots (only the main process writes these)
  int s_pll, s_rst;
  int s_cda [NCH];

  function automatic logic [W-1:0] rotl(input logic [W-1:0] v, input int r);
    logic [W-1:0] t;
    t = v;
    for (int i = 0; i < r; i++) t = {t[W-2:0], t[W-1]};
    return t;
  endfunction

  always @(posedge clk) begin
    if (load_tok != load_ack) begin
      for (int c = 0; c < NCH; c++) rot[c] <= rot_init[c];
      load_ack <= load_tok;
    end else begin
      for (int c = 0; c < NCH; c++)
        if (O_rx_cda[c] && !norot_m[c]) rot[c] <= (rot[c] + 1) % W;
    end
  end

  always_comb begin
    for (int c = 0; c < NCH; c++) begin
      I_rx_data[c*W +: W] = rotl(TRAIN, rot[c]);
      if (never_m[c]) I_rx_data[c*W +: W] = '0;
    end
    if (glitch) I_rx_data[W-1:0] = ~TRAIN;
  end

  always @(negedge clk) begin
    if (O_pll_areset) pll_cyc++;
    if (O_rx_cda_reset != '0) begin
      cdarst_cnt++;
      if (O_rx_cda_reset != '1) viol++;
    end
    for (int c = 0; c < NCH; c++) if (O_rx_cda[c]) cda_cnt[c]++;
    if ((O_rx_cda & prev_cda) != '0) viol++;
    if (O_rx_cda != '0 && O_rx_cda_reset != '0) viol++;
    if ($countones(O_rx_cda) > 1) viol++;
    prev_cda = O_rx_cda;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #2;
  endtask

  task automatic snap;
    s_pll = pll_cyc;
    s_rst = cdarst_cnt;
    for (int c = 0; c < NCH; c++) s_cda[c] = cda_cnt[c];
  endtask

  task automatic do_reset;
    I_rst   = 1'b1;
    I_start = 1'b0;
    glitch  = 1'b0;
    repeat (3) tick;
    chk("rst_pll",     O_pll_areset,   0);
    chk("rst_cdarst",  O_rx_cda_reset, 0);
    chk("rst_cda",     O_rx_cda,       0);
    chk("rst_busy",    O_busy,         0);
    chk("rst_done",    O_done,         0);
    chk("rst_aligned", O_aligned,      0);
    chk("rst_fail",    O_fail_mask,    0);
    I_rst = 1'b0;
    tick;
  endtask

  task automatic do_start;
    I_start = 1'b1;
    tick;
    I_start = 1'b0;
  endtask

  task automatic wait_done(input int budget, output int n);
    n = 0;
    while (!O_done && n < budget) begin
      tick;
      n++;
    end
    chk("done_seen", O_done, 1);
  endtask

  typedef struct {
    string            name;
    logic [NCH*4-1:0] rot;
    logic [NCH-1:0]   never;
    logic [NCH*4-1:0] exp_cda;
    logic [NCH-1:0]   exp_fail;
    logic             exp_aligned;
    int               exp_cycles;
  } vec_t;

  vec_t vecs [5];

  initial begin
    int n;
    int k;
    string nm;

    vecs[0] = '{"clean",     36'h000000000, 9'h000, 36'h000000000, 9'h000, 1'b1, 234};
    vecs[1] = '{"ch3_4slip", 36'h000006000, 9'h000, 36'h000004000, 9'h000, 1'b1, 274};
    vecs[2] = '{"ch7_never", 36'h000000000, 9'h080, 36'h090000000, 9'h080, 1'b0, 309};
    vecs[3] = '{"ch2_last",  36'h000000100, 9'h000, 36'h000000900, 9'h000, 1'b1, 324};
    vecs[4] = '{"mixed",     36'h900000003, 9'h020, 36'h100900007, 9'h020, 1'b0, 389};

    // ---- table-driven full bring-up runs, PLL already locked ----
    for (int v = 0; v < 5; v++) begin
      for (int c = 0; c < NCH; c++) rot_init[c] = int'(vecs[v].rot[c*4 +: 4]);
      never_m = vecs[v].never;
      norot_m = '0;
      load_tok++;
      I_rx_locked = 1'b1;
      do_reset;
      snap;
      do_start;
      wait_done(3000, n);
      nm = vecs[v].name;
      chk({nm, "_cycles"},  n,                     vecs[v].exp_cycles);
      chk({nm, "_aligned"}, O_aligned,             vecs[v].exp_aligned);
      chk({nm, "_fail"},    O_fail_mask,           vecs[v].exp_fail);
      chk({nm, "_busy"},    O_busy,                0);
      chk({nm, "_pllcyc"},  pll_cyc - s_pll,       16);
      chk({nm, "_cdarst"},  cdarst_cnt - s_rst,    1);
      for (int c = 0; c < NCH; c++)
        chk($sformatf("%s_cda%0d", nm, c), cda_cnt[c] - s_cda[c], int'(vecs[v].exp_cda[c*4 +: 4]));
    end

    // ---- lock arrives 20 cycles after start ----
    for (int c = 0; c < NCH; c++) rot_init[c] = 0;
    never_m = '0;
    load_tok++;
    I_rx_locked = 1'b0;
    do_reset;
    snap;
    do_start;
    n = 0;
    while (!O_done && n < 3000) begin
      if (n == 20) I_rx_locked = 1'b1;
      tick;
      n++;
    end
    chk("late_lock_done",    O_done,             1);
    chk("late_lock_cycles",  n,                  238);
    chk("late_lock_pllcyc",  pll_cyc - s_pll,    16);
    chk("late_lock_cdarst",  cdarst_cnt - s_rst, 1);
    chk("late_lock_nocda",   cda_cnt[0] + cda_cnt[1] + cda_cnt[2] + cda_cnt[3] + cda_cnt[4] +
                             cda_cnt[5] + cda_cnt[6] + cda_cnt[7] + cda_cnt[8] -
                             (s_cda[0] + s_cda[1] + s_cda[2] + s_cda[3] + s_cda[4] +
                              s_cda[5] + s_cda[6] + s_cda[7] + s_cda[8]), 0);
    chk("late_lock_aligned", O_aligned,          1);

    // ---- lock loss during channel-5 gap, with channel 2 already failed ----
    for (int c = 0; c < NCH; c++) rot_init[c] = 0;
    rot_init[5] = 5;
    never_m = 9'h004;
    load_tok++;
    I_rx_locked = 1'b1;
    do_reset;
    snap;
    do_start;
    k = 0;
    while (cda_cnt[5] == s_cda[5] && k < 3000) begin
      tick;
      k++;
    end
    chk("ll_slip5_seen", cda_cnt[5] - s_cda[5], 1);
    chk("ll_mask_before", O_fail_mask, 9'h004);
    I_rx_locked = 1'b0;
    tick;
    chk("ll_mask_cleared", O_fail_mask, 0);
    chk("ll_busy",         O_busy,      1);
    chk("ll_done",         O_done,      0);
    snap;
    repeat (20) tick;
    chk("ll_no_cda5",   cda_cnt[5] - s_cda[5],  0);
    chk("ll_no_cdarst", cdarst_cnt - s_rst,     0);
    never_m = '0;
    snap;
    I_rx_locked = 1'b1;
    wait_done(3000, n);
    chk("ll_relock_cycles", n,                     268);
    chk("ll_relock_cdarst", cdarst_cnt - s_rst,    1);
    chk("ll_relock_pll",    pll_cyc - s_pll,       0);
    chk("ll_relock_cda5",   cda_cnt[5] - s_cda[5], 4);
    chk("ll_relock_cda2",   cda_cnt[2] - s_cda[2], 1);
    chk("ll_relock_fail",   O_fail_mask,           0);
    chk("ll_relock_aligned", O_aligned,            1);

    // ---- start and lock loss together in DONE: start wins ----
    never_m = 9'h080;
    I_start = 1'b1;
    I_rx_locked = 1'b0;
    tick;
    I_start = 1'b0;
    chk("sw_pll",  O_pll_areset, 1);
    chk("sw_done", O_done,       0);
    chk("sw_busy", O_busy,       1);
    repeat (30) tick;
    I_rx_locked = 1'b1;
    wait_done(3000, n);
    chk("sw_fail",    O_fail_mask, 9'h080);
    chk("sw_aligned", O_aligned,   0);
    // start in DONE clears the result
    do_start;
    chk("rs_fail",    O_fail_mask,  0);
    chk("rs_done",    O_done,       0);
    chk("rs_aligned", O_aligned,    0);
    chk("rs_pll",     O_pll_areset, 1);
    wait_done(3000, n);
    chk("rs_fail2", O_fail_mask, 9'h080);
    // lock loss alone in DONE
    I_rx_locked = 1'b0;
    tick;
    chk("dl_busy", O_busy,       1);
    chk("dl_done", O_done,       0);
    chk("dl_fail", O_fail_mask,  0);
    chk("dl_pll",  O_pll_areset, 0);
    I_rx_locked = 1'b1;

    // ---- channel 0 matches 15 cycles, then one mismatch ----
    for (int c = 0; c < NCH; c++) rot_init[c] = 0;
    never_m = '0;
    norot_m = 9'h001;
    load_tok++;
    do_reset;
    snap;
    do_start;
    n = 0;
    while (!O_done && n < 3000) begin
      if (n == 96) glitch = 1'b1;
      if (n == 97) glitch = 1'b0;
      tick;
      n++;
    end
    chk("gl_done",    O_done,                1);
    chk("gl_cycles",  n,                     259);
    chk("gl_cda0",    cda_cnt[0] - s_cda[0], 1);
    chk("gl_aligned", O_aligned,             1);
    norot_m = '0;

    // ---- reset while PLL reset is asserted, then ignored start during CHECK ----
    do_reset;
    do_start;
    repeat (5) tick;
    chk("mr_pll_high", O_pll_areset, 1);
    I_rst = 1'b1;
    tick;
    chk("mr_pll",  O_pll_areset, 0);
    chk("mr_busy", O_busy,       0);
    chk("mr_done", O_done,       0);
    chk("mr_fail", O_fail_mask,  0);
    I_rst = 1'b0;
    snap;
    repeat (20) tick;
    chk("mr_idle_pll",  pll_cyc - s_pll, 0);
    chk("mr_idle_busy", O_busy,          0);
    do_start;
    n = 0;
    while (!O_done && n < 3000) begin
      if (n == 90) begin
        snap;
        I_start = 1'b1;
      end
      tick;
      n++;
      I_start = 1'b0;
    end
    chk("ig_done",    O_done,          1);
    chk("ig_cycles",  n,               234);
    chk("ig_no_pll",  pll_cyc - s_pll, 0);
    chk("ig_aligned", O_aligned,       1);

    chk("protocol_violations", viol, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
